mult_booth: RTL and testbench

MULT_BOOTH -- requirements
Module: mult_booth

---
 rtl/mult_booth.sv | 108 ++++++++++
 tb/tb_mult_booth.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_booth.sv
// Signed 32x32 radix-2 Booth multiplier, one step per clock.
// Three-state FSM; HI/LO registers update only when a product completes.
module mult_booth (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic        mult_busy,
  output logic        mult_done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        start_ok;
  logic        last;
  logic [32:0] m;
  logic [32:0] acc;
  logic [32:0] sum;
  logic [32:0] acc_sh;
  logic [31:0] q;
  logic [31:0] q_sh;
  logic        q_m1;
  logic [4:0]  cnt;

  assign last = (cnt == 5'd31);

  // 33-bit accumulator keeps -(-2^31) representable
  always_comb begin
    sum = acc;
    unique case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_sh = {sum[32], sum[32:1]};
    q_sh   = {sum[0], q[31:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mult_start) begin
          state_nxt = RUN;
          start_ok  = 1'b1;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (mult_start) begin
          state_nxt = RUN;
          start_ok  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mult_busy = (state == RUN);
  assign mult_done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m      <= '0;
      acc    <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else if (start_ok) begin
      m    <= {A_in[31], A_in};
      acc  <= '0;
      q    <= B_in;
      q_m1 <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      acc  <= acc_sh;
      q    <= q_sh;
      q_m1 <= q[0];
      cnt  <= cnt + 5'd1;
      if (last) begin
        hi_out <= acc_sh[31:0];
        lo_out <= q_sh;
      end
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// Directed self-checking bench for mult_booth.
// Each task drives one scenario and checks its own results.
module tb_mult_booth;

  logic        clk;
  logic        reset;
  logic        mult_start;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic        mult_busy;
  logic        mult_done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_vec;
  int n_err;

  mult_booth dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .A_in       (A_in),
    .B_in       (B_in),
    .mult_busy  (mult_busy),
    .mult_done  (mult_done),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a one-cycle start, then wait (bounded) for mult_done.
  task automatic run_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output int          busy_cnt
  );
    A_in       = a;
    B_in       = b;
    mult_start = 1'b1;
    @(posedge clk); #1;
    mult_start = 1'b0;
    lat        = -1;
    busy_cnt   = 0;
    for (int k = 1; k <= 40; k++) begin
      if (mult_busy) busy_cnt++;
      @(posedge clk); #1;
      if (mult_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset      = 1'b0;
    mult_start = 1'b0;
    A_in       = '0;
    B_in       = '0;
    #2;
    n_vec++;
    if (mult_busy !== 1'b0 || mult_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0",
               mult_busy, mult_done);
    end
    n_vec++;
    if ({hi_out, lo_out} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_prod got %h want 0", {hi_out, lo_out});
    end
    #20 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat, bc;
    run_op(32'd9, 32'd7, lat, bc);
    n_vec++;
    if (lat !== 32) begin
      n_err++;
      $display("FAIL basic_latency got %0d want 32", lat);
    end
    n_vec++;
    if (bc !== 32) begin
      n_err++;
      $display("FAIL basic_busy_cycles got %0d want 32", bc);
    end
    n_vec++;
    if ({hi_out, lo_out} !== 64'h0000_0000_0000_003F) begin
      n_err++;
      $display("FAIL basic_prod got %h want 3f", {hi_out, lo_out});
    end
    @(posedge clk); #1;
    n_vec++;
    if (mult_done !== 1'b0 || mult_busy !== 1'b0 ||
        lo_out !== 32'h3F) begin
      n_err++;
      $display("FAIL basic_idle done=%b busy=%b lo=%h want 0 0 3f",
               mult_done, mult_busy, lo_out);
    end
  endtask

  task automatic test_mixed;
    int lat, bc;
    run_op(32'hFFFF_FFFA, 32'd5, lat, bc);
    n_vec++;
    if (lat !== 32 ||
        {hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFE2) begin
      n_err++;
      $display("FAIL mixed_sign lat=%0d got %h want ffffffffffffffe2",
               lat, {hi_out, lo_out});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_extreme;
    int lat, bc;
    run_op(32'h8000_0000, 32'h8000_0000, lat, bc);
    n_vec++;
    if (lat !== 32 ||
        {hi_out, lo_out} !== 64'h4000_0000_0000_0000) begin
      n_err++;
      $display("FAIL min_x_min lat=%0d got %h want 4000000000000000",
               lat, {hi_out, lo_out});
    end
    @(posedge clk); #1;
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    n_vec++;
    if (lat !== 32 ||
        {hi_out, lo_out} !== 64'hFFFF_FFFF_8000_0001) begin
      n_err++;
      $display("FAIL max_x_neg1 lat=%0d got %h want ffffffff80000001",
               lat, {hi_out, lo_out});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int lat, bc, dn;
    A_in       = 32'd9;
    B_in       = 32'd7;
    mult_start = 1'b1;
    @(posedge clk); #1;
    mult_start = 1'b0;
    A_in       = 32'd1;
    B_in       = 32'd1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    n_vec++;
    if (mult_busy !== 1'b1 ||
        {hi_out, lo_out} !== 64'hFFFF_FFFF_8000_0001) begin
      n_err++;
      $display("FAIL hold_in_run busy=%b got %h want 1 ffffffff80000001",
               mult_busy, {hi_out, lo_out});
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (mult_busy !== 1'b0 || mult_done !== 1'b0 ||
        {hi_out, lo_out} !== 64'h0) begin
      n_err++;
      $display("FAIL abort_async busy=%b done=%b prod=%h want 0 0 0",
               mult_busy, mult_done, {hi_out, lo_out});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    dn    = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (mult_done || mult_busy) dn++;
    end
    n_vec++;
    if (dn !== 0) begin
      n_err++;
      $display("FAIL abort_no_done active_cycles=%0d want 0", dn);
    end
    run_op(32'd6, 32'd5, lat, bc);
    n_vec++;
    if (lat !== 32 || {hi_out, lo_out} !== 64'h1E) begin
      n_err++;
      $display("FAIL after_abort lat=%0d got %h want 1e",
               lat, {hi_out, lo_out});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int dn;
    logic [63:0] res;
    A_in       = 32'd9;
    B_in       = 32'd7;
    mult_start = 1'b1;
    @(posedge clk); #1;
    mult_start = 1'b0;
    dn         = 0;
    res        = '0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 6) begin
        A_in       = 32'd5;
        B_in       = 32'd5;
        mult_start = 1'b1;
      end else begin
        mult_start = 1'b0;
      end
      @(posedge clk); #1;
      if (mult_done) begin
        dn++;
        res = {hi_out, lo_out};
      end
    end
    n_vec++;
    if (dn !== 1) begin
      n_err++;
      $display("FAIL ignore_done_count got %0d want 1", dn);
    end
    n_vec++;
    if (res !== 64'd63) begin
      n_err++;
      $display("FAIL ignore_result got %h want 3f", res);
    end
  endtask

  task automatic test_back_to_back;
    int d1, d2;
    logic [63:0] r1, r2;
    d1         = -1;
    d2         = -1;
    r1         = '0;
    r2         = '0;
    A_in       = 32'd3;
    B_in       = 32'd4;
    mult_start = 1'b1;
    @(posedge clk); #1;
    A_in = 32'd2;
    B_in = 32'hFFFF_FFFE;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (mult_done) begin
        if (d1 < 0) begin
          d1 = k;
          r1 = {hi_out, lo_out};
        end else begin
          d2 = k;
          r2 = {hi_out, lo_out};
          break;
        end
      end
    end
    mult_start = 1'b0;
    n_vec++;
    if (d1 !== 32 || r1 !== 64'd12) begin
      n_err++;
      $display("FAIL b2b_first at=%0d got %h want 32 c", d1, r1);
    end
    n_vec++;
    if (r2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_err++;
      $display("FAIL b2b_second got %h want fffffffffffffffc", r2);
    end
    n_vec++;
    if (d2 - d1 !== 33) begin
      n_err++;
      $display("FAIL b2b_spacing got %0d want 33", d2 - d1);
    end
    @(posedge clk); #1;
    n_vec++;
    if (mult_busy !== 1'b0 || mult_done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle busy=%b done=%b want 0 0",
               mult_busy, mult_done);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_mixed();
    test_extreme();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
